srt_div_ctrl: RTL and testbench

SRT_DIV_CTRL -- requirements
Module: srt_div_ctrl

---
 rtl/srt_pkg.sv | 24 ++
 rtl/quotient_selector.sv | 43 ++++
 rtl/srt_div_ctrl.sv | 134 +++++++++++++
 tb/tb_srt_div_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/srt_pkg.sv
// Shared constants and types for the radix-2 SRT divider.
// Datapath widths derive from the operand width.
package srt_pkg;

  function automatic int rem_w(input int w);
    return w + 2;
  endfunction

  function automatic int qacc_w(input int w);
    return w + 3;
  endfunction

  localparam int WIDTH  = 6;
  localparam int REM_W  = rem_w(WIDTH);
  localparam int QACC_W = qacc_w(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    CORR,
    DONE
  } state_t;

endpackage

// File: rtl/quotient_selector.sv
// SRT digit selection in -2..+2 from exact partial remainder and divisor.
// Thresholds at +-D/2 and +-3D/2 keep the next remainder within +-D.
module quotient_selector
  import srt_pkg::*;
#(
  parameter int RW = REM_W
) (
  input  logic signed [RW-1:0] rem_msb,
  input  logic        [RW-1:0] div_msb,
  output logic signed [2:0]    q
);

  localparam int XW = RW + 3;

  logic signed [XW-1:0] r2;
  logic signed [XW-1:0] d1;
  logic signed [XW-1:0] d3;
  logic gt3;
  logic gt1;
  logic lt1;
  logic lt3;

  assign r2 = {{2{rem_msb[RW-1]}}, rem_msb, 1'b0};
  assign d1 = {3'b000, div_msb};
  assign d3 = d1 + (d1 <<< 1);

  assign gt3 = (r2 > d3);
  assign gt1 = (r2 > d1) && !gt3;
  assign lt3 = (r2 < -d3);
  assign lt1 = (r2 < -d1) && !lt3;

  always_comb begin
    q = 3'sd0;
    unique case (1'b1)
      gt3:     q = 3'sd2;
      gt1:     q = 3'sd1;
      lt1:     q = -3'sd1;
      lt3:     q = -3'sd2;
      default: q = 3'sd0;
    endcase
  end

endmodule

// File: rtl/srt_div_ctrl.sv
// Radix-2 SRT unsigned divider: one digit per cycle, then one
// correction step that folds the redundant result into range.
module srt_div_ctrl
  import srt_pkg::*;
#(
  parameter int WIDTH = srt_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int RW = rem_w(WIDTH);
  localparam int QW = qacc_w(WIDTH);
  localparam int CW = $clog2(WIDTH);

  state_t state;

  logic signed [RW-1:0] rem;
  logic signed [RW-1:0] r;
  logic signed [RW-1:0] qd;
  logic signed [RW-1:0] rem_nx;
  logic signed [RW-1:0] rem_c;
  logic signed [QW-1:0] qacc;
  logic signed [QW-1:0] qacc_nx;
  logic signed [QW-1:0] qacc_c;
  logic [WIDTH-1:0] dreg;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    dext;
  logic signed [2:0] q;
  logic zpend;
  logic accept;
  logic last;

  assign dext = {{(RW-WIDTH){1'b0}}, dreg};
  assign r    = {rem[RW-2:0], sreg[WIDTH-1]};

  quotient_selector #(
    .RW(RW)
  ) u_qsel (
    .rem_msb(r),
    .div_msb(dext),
    .q      (q)
  );

  assign qd      = RW'(q) * $signed(dext);
  assign rem_nx  = r - qd;
  assign qacc_nx = (qacc <<< 1) + QW'(q);

  always_comb begin
    rem_c  = rem;
    qacc_c = qacc;
    if (rem[RW-1]) begin
      rem_c  = rem + $signed(dext);
      qacc_c = qacc - QW'(1);
    end else if (rem == $signed(dext)) begin
      rem_c  = rem - $signed(dext);
      qacc_c = qacc + QW'(1);
    end
  end

  assign accept = start && !zpend &&
                  (state == IDLE || state == DONE);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rem         <= '0;
      qacc        <= '0;
      dreg        <= '0;
      sreg        <= '0;
      cnt         <= '0;
      zpend       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (zpend) begin
        zpend       <= 1'b0;
        state       <= DONE;
        done        <= 1'b1;
        quotient    <= '1;
        remainder   <= sreg;
        div_by_zero <= 1'b1;
      end else if (accept) begin
        sreg <= dividend;
        if (divisor == '0) begin
          zpend <= 1'b1;
        end else begin
          rem   <= '0;
          qacc  <= '0;
          dreg  <= divisor;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= ITER;
        end
      end else begin
        case (state)
          ITER: begin
            rem  <= rem_nx;
            qacc <= qacc_nx;
            sreg <= sreg << 1;
            cnt  <= cnt + CW'(1);
            if (last) state <= CORR;
          end
          CORR: begin
            rem         <= rem_c;
            qacc        <= qacc_c;
            quotient    <= qacc_c[WIDTH-1:0];
            remainder   <= rem_c[WIDTH-1:0];
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_srt_div_ctrl.sv
// Scoreboard bench for srt_div_ctrl: directed vectors,
// ignored start, mid-run reset and a full operand sweep.
module tb_srt_div_ctrl;

  typedef struct {
    logic [5:0] q;
    logic [5:0] r;
    logic       dz;
    int         due;
    int         bsy;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] dividend;
  logic [5:0] divisor;
  logic       busy;
  logic       done;
  logic [5:0] quotient;
  logic [5:0] remainder;
  logic       div_by_zero;

  exp_t sb[$];
  exp_t me;
  int   errors;
  int   checks;
  int   cyc;
  int   busycnt;
  int   rv;
  logic [5:0] hq;
  logic [5:0] hr;
  logic       hdz;
  logic       rs;

  int va[5] = '{45, 63, 0, 5, 10};
  int vb[5] = '{7, 1, 5, 63, 0};
  int vq[5] = '{6, 63, 0, 0, 63};
  int vr[5] = '{3, 0, 0, 5, 10};
  int vz[5] = '{0, 0, 0, 0, 1};

  srt_div_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input int got,
                     input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)",
               nm, got, want, cyc);
    end
  endtask

  always @(posedge clk) begin
    rs = rst_n;
    #1;
    if (!rs) begin
      busycnt = 0;
      hq  = '0;
      hr  = '0;
      hdz = 1'b0;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_quotient", int'(quotient), 0);
      chk("rst_remainder", int'(remainder), 0);
      chk("rst_dz", int'(div_by_zero), 0);
    end else begin
      if (busy) begin
        busycnt++;
        rv = int'(dut.rem);
        if (rv < 0) rv = -rv;
        chk("rem_bound", int'(rv <= int'(dut.dreg)), 1);
        chk("held_result",
            int'({quotient, remainder, div_by_zero}),
            int'({hq, hr, hdz}));
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          me = sb.pop_front();
          chk("quotient", int'(quotient), int'(me.q));
          chk("remainder", int'(remainder), int'(me.r));
          chk("div_by_zero", int'(div_by_zero), int'(me.dz));
          chk("latency", cyc, me.due);
          chk("busy_cycles", busycnt, me.bsy);
          hq  = me.q;
          hr  = me.r;
          hdz = me.dz;
        end
        busycnt = 0;
      end
    end
  end

  task automatic issue(input int a, input int b,
                       input int q, input int r,
                       input int dz, input bit push);
    exp_t e;
    start    = 1'b1;
    dividend = 6'(a);
    divisor  = 6'(b);
    @(posedge clk);
    #2;
    start    = 1'b0;
    dividend = 6'($urandom);
    divisor  = 6'($urandom);
    if (push) begin
      e.q   = 6'(q);
      e.r   = 6'(r);
      e.dz  = (dz != 0);
      e.due = cyc + ((b == 0) ? 1 : 7);
      e.bsy = (b == 0) ? 0 : 7;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0) return;
    end
    chk("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_done();
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #2;
      if (done) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      issue(va[i], vb[i], vq[i], vr[i], vz[i], 1'b1);
      drain();
    end

    issue(45, 7, 6, 3, 0, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    start    = 1'b1;
    dividend = 6'd20;
    divisor  = 6'd3;
    @(posedge clk);
    #2;
    start = 1'b0;
    drain();

    issue(45, 7, 0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    issue(9, 2, 4, 1, 0, 1'b1);
    drain();

    for (int a = 0; a < 64; a++) begin
      for (int b = 1; b < 64; b++) begin
        issue(a, b, a / b, a % b, 0, 1'b1);
        wait_done();
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
